pipeline_control_unit: RTL



---
 rtl/pipeline_control_unit_if.sv | 44 ++++
 rtl/pipeline_control_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit_if.sv
// Hazard/event inputs and stage-control outputs of the pipeline control unit.
// The master side belongs to the datapath, which raises the hazard and event
// requests and consumes the enables and bubbles. The slave side is the control unit.
interface pipeline_control_unit_if #(
    parameter int CNT_W = 32
);
    // hazard / multi-cycle event requests
    logic             load_use_i;
    logic             redirect_ex_i;
    logic             muldiv_start_ex_i;
    logic             muldiv_done_i;
    logic             dmem_req_mem_i;
    logic             dmem_ready_i;
    // per-stage register controls
    logic             en_if;
    logic             en_id;
    logic             en_ex;
    logic             en_mem;
    logic             en_wb;
    logic             flush_if_id;
    logic             bubble_ex;
    logic             bubble_mem;
    logic             bubble_wb;
    // status
    logic             timeout_err;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output load_use_i, redirect_ex_i, muldiv_start_ex_i, muldiv_done_i,
               dmem_req_mem_i, dmem_ready_i,
        input  en_if, en_id, en_ex, en_mem, en_wb,
               flush_if_id, bubble_ex, bubble_mem, bubble_wb,
               timeout_err, state_o, stall_cnt_o
    );

    modport slave (
        input  load_use_i, redirect_ex_i, muldiv_start_ex_i, muldiv_done_i,
               dmem_req_mem_i, dmem_ready_i,
        output en_if, en_id, en_ex, en_mem, en_wb,
               flush_if_id, bubble_ex, bubble_mem, bubble_wb,
               timeout_err, state_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_control_unit.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Stage controls are Mealy outputs of the state and the inputs. The FSM only
// tracks the multi-cycle waits: dmem wait states, the iterative mul/div unit,
// and a terminal hang state that a watchdog enters.
module pipeline_control_unit #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_control_unit_if.slave bus
);
    localparam int WCW = $clog2(TIMEOUT);
    localparam logic [WCW-1:0] WMAX = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        DMEM_WAIT   = 2'd1,
        MULDIV_WAIT = 2'd2,
        ERROR       = 2'd3
    } state_t;

    typedef struct packed {
        logic en_if;
        logic en_id;
        logic en_ex;
        logic en_mem;
        logic en_wb;
        logic flush_if_id;
        logic bubble_ex;
        logic bubble_mem;
        logic bubble_wb;
    } ctrl_t;

    // control patterns: {en_if..en_wb, flush_if_id, bubble_ex/mem/wb}
    localparam ctrl_t C_OFF    = ctrl_t'(9'b00000_0000);
    localparam ctrl_t C_RUN    = ctrl_t'(9'b11111_0000);
    localparam ctrl_t C_DSTALL = ctrl_t'(9'b00001_0001); // drain WB, freeze rest
    localparam ctrl_t C_MSTALL = ctrl_t'(9'b00011_0010); // freeze EX, MEM eats bubbles
    localparam ctrl_t C_REDIR  = ctrl_t'(9'b11111_1100); // kill wrong-path IF/ID and ID/EX
    localparam ctrl_t C_LU     = ctrl_t'(9'b00111_0100); // hold IF/ID one cycle

    state_t           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_q;
    ctrl_t            ctrl;

    // Next-state and stage controls. DMEM_WAIT release re-runs the RUN
    // priority chain without the dmem term so pending work lands immediately.
    always_comb begin
        ctrl    = C_OFF;
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            RUN, DMEM_WAIT: begin
                if (state_q == DMEM_WAIT && !bus.dmem_ready_i) begin
                    ctrl = C_DSTALL;
                    if (wcnt_q == WMAX) state_d = ERROR;
                    else                wcnt_d  = wcnt_q + 1'b1;
                end else begin
                    ctrl    = C_RUN;
                    state_d = RUN;
                    if (state_q == RUN && bus.dmem_req_mem_i && !bus.dmem_ready_i) begin
                        ctrl    = C_DSTALL;
                        state_d = DMEM_WAIT;
                        wcnt_d  = '0;
                    end else if (bus.muldiv_start_ex_i) begin
                        ctrl    = C_MSTALL;
                        state_d = MULDIV_WAIT;
                        wcnt_d  = '0;
                    end else if (bus.redirect_ex_i) begin
                        ctrl = C_REDIR;
                    end else if (bus.load_use_i) begin
                        ctrl = C_LU;
                    end
                end
            end
            MULDIV_WAIT: begin
                // EX is frozen, so every other request is re-seen after release
                if (!bus.muldiv_done_i) begin
                    ctrl = C_MSTALL;
                    if (wcnt_q == WMAX) state_d = ERROR;
                    else                wcnt_d  = wcnt_q + 1'b1;
                end else begin
                    ctrl    = C_RUN;
                    state_d = RUN;
                end
            end
            ERROR: begin
                ctrl = C_OFF;
            end
            default: begin
                ctrl    = C_OFF;
                state_d = ERROR;
            end
        endcase
        if (!rst_n) ctrl = C_OFF;
    end

    // State, watchdog counter and saturating stall counter share one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (!ctrl.en_if && stall_q != '1) stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.en_if       = ctrl.en_if;
    assign bus.en_id       = ctrl.en_id;
    assign bus.en_ex       = ctrl.en_ex;
    assign bus.en_mem      = ctrl.en_mem;
    assign bus.en_wb       = ctrl.en_wb;
    assign bus.flush_if_id = ctrl.flush_if_id;
    assign bus.bubble_ex   = ctrl.bubble_ex;
    assign bus.bubble_mem  = ctrl.bubble_mem;
    assign bus.bubble_wb   = ctrl.bubble_wb;
    assign bus.timeout_err = rst_n && (state_q == ERROR);
    assign bus.state_o     = state_q;
    assign bus.stall_cnt_o = stall_q;
endmodule
